// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit scheduler: FSM states and frame constants.
package udp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        GAP
    } sched_state_t;

    localparam int UDP_HDR_BYTES      = 8;
    localparam int DEFAULT_GAP_CYCLES = 24;

endpackage

// File: rtl/udp_tx_sched_if.sv
// Bundle of requester, udp_tx header serializer and merged-stream signals around udp_tx_sched.
interface udp_tx_sched_if #(
    parameter int NREQ = 2,
    parameter int N    = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*16-1:0] req_src_port;
    logic [NREQ*16-1:0] req_dst_port;
    logic [NREQ*16-1:0] req_length;
    logic [NREQ*16-1:0] req_cksum;
    logic [NREQ-1:0]    grant;

    logic [15:0]        src_port_out;
    logic [15:0]        dst_port_out;
    logic [15:0]        data_length_out;
    logic [15:0]        data_checksum_out;
    logic               hdr_start;
    logic               hdr_valid;
    logic               hdr_last;
    logic [N-1:0]       hdr_data;

    logic [NREQ-1:0]    pl_valid;
    logic [NREQ*N-1:0]  pl_data;
    logic [NREQ-1:0]    pl_ready;

    logic               axiov;
    logic [N-1:0]       axiod;
    logic               axi_last;
    logic               underrun;

    // master is the scheduler; slave is the surrounding sources, serializer and framer
    modport master (
        input  req_valid, req_src_port, req_dst_port, req_length, req_cksum,
        input  hdr_valid, hdr_last, hdr_data, pl_valid, pl_data,
        output grant, src_port_out, dst_port_out, data_length_out, data_checksum_out,
        output hdr_start, pl_ready, axiov, axiod, axi_last, underrun
    );

    modport slave (
        output req_valid, req_src_port, req_dst_port, req_length, req_cksum,
        output hdr_valid, hdr_last, hdr_data, pl_valid, pl_data,
        input  grant, src_port_out, dst_port_out, data_length_out, data_checksum_out,
        input  hdr_start, pl_ready, axiov, axiod, axi_last, underrun
    );

endinterface

// File: rtl/udp_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    always_comb begin
        int   j;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/udp_tx_sched.sv
// UDP transmit frame scheduler: round-robin pick, header forwarding, payload splice, gap.
module udp_tx_sched
    import udp_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int N          = 4,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input logic          clk,
    input logic          rst,
    udp_tx_sched_if.master bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SH = $clog2(N);

    sched_state_t state, state_n;
    logic [IW-1:0]   rr_ptr, rr_ptr_n;
    logic [IW-1:0]   gidx, gidx_n;
    logic [NREQ-1:0] grant_r, grant_n;
    logic [18:0]     nib_cnt, nib_cnt_n;
    logic [15:0]     gap_cnt, gap_cnt_n;
    logic [15:0]     src_r, src_n, dst_r, dst_n, len_r, len_n, ck_r, ck_n;
    logic            axiov_r, axiov_n, last_r, last_n, under_r, under_n;
    logic [N-1:0]    axiod_r, axiod_n;

    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_idx;
    logic [18:0]     len_nibs;

    logic [15:0]  src_arr [NREQ];
    logic [15:0]  dst_arr [NREQ];
    logic [15:0]  len_arr [NREQ];
    logic [15:0]  ck_arr  [NREQ];
    logic [N-1:0] pl_arr  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_split
        assign src_arr[i] = bus.req_src_port[i*16 +: 16];
        assign dst_arr[i] = bus.req_dst_port[i*16 +: 16];
        assign len_arr[i] = bus.req_length[i*16 +: 16];
        assign ck_arr[i]  = bus.req_cksum[i*16 +: 16];
        assign pl_arr[i]  = bus.pl_data[i*N +: N];
    end

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    // payload length in bytes converted to stream beats (bytes * 8 / N)
    assign len_nibs = {3'b000, len_r} << (3 - SH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            gidx    <= '0;
            grant_r <= '0;
            nib_cnt <= '0;
            gap_cnt <= '0;
            src_r   <= '0;
            dst_r   <= '0;
            len_r   <= '0;
            ck_r    <= '0;
            axiov_r <= 1'b0;
            axiod_r <= '0;
            last_r  <= 1'b0;
            under_r <= 1'b0;
        end else begin
            state   <= state_n;
            rr_ptr  <= rr_ptr_n;
            gidx    <= gidx_n;
            grant_r <= grant_n;
            nib_cnt <= nib_cnt_n;
            gap_cnt <= gap_cnt_n;
            src_r   <= src_n;
            dst_r   <= dst_n;
            len_r   <= len_n;
            ck_r    <= ck_n;
            axiov_r <= axiov_n;
            axiod_r <= axiod_n;
            last_r  <= last_n;
            under_r <= under_n;
        end
    end

    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        gidx_n    = gidx;
        grant_n   = grant_r;
        nib_cnt_n = nib_cnt;
        gap_cnt_n = gap_cnt;
        src_n     = src_r;
        dst_n     = dst_r;
        len_n     = len_r;
        ck_n      = ck_r;
        axiov_n   = 1'b0;
        axiod_n   = '0;
        last_n    = 1'b0;
        under_n   = 1'b0;

        case (state)
            IDLE: begin
                if (|bus.req_valid) begin
                    gidx_n   = arb_idx;
                    grant_n  = arb_grant;
                    src_n    = src_arr[arb_idx];
                    dst_n    = dst_arr[arb_idx];
                    len_n    = len_arr[arb_idx];
                    ck_n     = ck_arr[arb_idx];
                    rr_ptr_n = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
                    state_n  = HEADER;
                end
            end
            HEADER: begin
                if (bus.hdr_valid) begin
                    axiov_n = 1'b1;
                    axiod_n = bus.hdr_data;
                    if (bus.hdr_last) begin
                        if (len_r == 16'd0) begin
                            last_n    = 1'b1;
                            grant_n   = '0;
                            gap_cnt_n = '0;
                            state_n   = GAP;
                        end else begin
                            nib_cnt_n = len_nibs;
                            state_n   = PAYLOAD;
                        end
                    end
                end
            end
            PAYLOAD: begin
                // a missing beat mid-payload aborts the frame without axi_last
                if (bus.pl_valid[gidx]) begin
                    axiov_n   = 1'b1;
                    axiod_n   = pl_arr[gidx];
                    nib_cnt_n = nib_cnt - 19'd1;
                    if (nib_cnt == 19'd1) begin
                        last_n    = 1'b1;
                        grant_n   = '0;
                        gap_cnt_n = '0;
                        state_n   = GAP;
                    end
                end else begin
                    under_n   = 1'b1;
                    grant_n   = '0;
                    gap_cnt_n = '0;
                    state_n   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == 16'(GAP_CYCLES - 1)) begin
                    state_n = IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.grant             = grant_r;
    assign bus.src_port_out      = src_r;
    assign bus.dst_port_out      = dst_r;
    assign bus.data_length_out   = len_r;
    assign bus.data_checksum_out = ck_r;
    assign bus.hdr_start         = (state == HEADER);
    assign bus.pl_ready          = (state == PAYLOAD) ? grant_r : '0;
    assign bus.axiov             = axiov_r;
    assign bus.axiod             = axiod_r;
    assign bus.axi_last          = last_r;
    assign bus.underrun          = under_r;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed scoreboard bench for udp_tx_sched with a behavioural udp_tx header serializer.
module tb_udp_tx_sched;
    import udp_pkg::*;

    localparam int NREQ     = 2;
    localparam int N        = 4;
    localparam int GAP      = 24;
    localparam int HDR_NIBS = UDP_HDR_BYTES * 8 / N;
    localparam int LIM      = 500;

    typedef struct packed {
        logic [3:0] data;
        logic       last;
    } exp_t;

    logic clk;
    logic rst;
    udp_tx_sched_if #(.NREQ(NREQ), .N(N)) bus ();

    udp_tx_sched #(.NREQ(NREQ), .N(N), .GAP_CYCLES(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int checks;
    int errors;
    int under_cnt;
    bit ready_seen;
    int pl_idx [NREQ];
    int pl_limit;
    logic [NREQ-1:0] pl_en;
    int hdr_idx;
    logic [63:0] hdr_word;
    int n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] nib(input int i, input int k);
        return 4'((i * 7 + k * 3 + 1) & 15);
    endfunction

    // payload sources: each restarts its sequence whenever it is not being served
    for (genvar i = 0; i < NREQ; i++) begin : g_src
        assign bus.pl_data[i*N +: N] = nib(i, pl_idx[i]);
        assign bus.pl_valid[i]       = pl_en[i] && (pl_idx[i] < pl_limit);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (bus.pl_ready[i] && bus.pl_valid[i]) begin
                pl_idx[i] <= pl_idx[i] + 1;
            end else if (!bus.pl_ready[i]) begin
                pl_idx[i] <= 0;
            end
        end
    end

    // udp_tx stand-in: serializes src, dst, length+8, checksum MSB nibble first
    always @(negedge clk) begin
        if (bus.hdr_start) begin
            if (hdr_idx == 0) begin
                hdr_word = {bus.src_port_out, bus.dst_port_out,
                            bus.data_length_out + 16'(UDP_HDR_BYTES), bus.data_checksum_out};
            end
            bus.hdr_valid = 1'b1;
            bus.hdr_data  = hdr_word[63 - 4*hdr_idx -: 4];
            bus.hdr_last  = (hdr_idx == HDR_NIBS - 1);
            hdr_idx       = (hdr_idx == HDR_NIBS - 1) ? 0 : hdr_idx + 1;
        end else begin
            bus.hdr_valid = 1'b0;
            bus.hdr_last  = 1'b0;
            bus.hdr_data  = '0;
            hdr_idx       = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.underrun === 1'b1) under_cnt++;
        if (bus.pl_ready !== '0) ready_seen = 1'b1;
        if (bus.axiov === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", 32'(bus.axiov), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("axiod", 32'(bus.axiod), 32'(mon_e.data));
                checkOutput("axi_last", 32'(bus.axi_last), 32'(mon_e.last));
            end
        end
    end

    task automatic applyStimulus(input int who, input logic [15:0] src, input logic [15:0] dst,
                                 input logic [15:0] len, input logic [15:0] ck);
        bus.req_src_port[who*16 +: 16] = src;
        bus.req_dst_port[who*16 +: 16] = dst;
        bus.req_length[who*16 +: 16]   = len;
        bus.req_cksum[who*16 +: 16]    = ck;
        bus.req_valid[who]             = 1'b1;
    endtask

    task automatic pushFrame(input int who, input logic [15:0] src, input logic [15:0] dst,
                             input logic [15:0] len, input logic [15:0] ck,
                             input int pl_cnt, input bit with_last);
        logic [63:0] h;
        exp_t e;
        h = {src, dst, len + 16'(UDP_HDR_BYTES), ck};
        for (int i = 0; i < HDR_NIBS; i++) begin
            e.data = h[63 - 4*i -: 4];
            e.last = with_last && (pl_cnt == 0) && (i == HDR_NIBS - 1);
            sb.push_back(e);
        end
        for (int k = 0; k < pl_cnt; k++) begin
            e.data = nib(who, k);
            e.last = with_last && (k == pl_cnt - 1);
            sb.push_back(e);
        end
    endtask

    task automatic waitGrantHigh(output int cnt);
        cnt = 0;
        while (bus.grant == '0 && cnt < LIM) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= LIM) checkOutput("grant_timeout", 32'(bus.grant != '0), 32'd1);
    endtask

    task automatic waitGrantLow();
        int c;
        c = 0;
        while (bus.grant != '0 && c < LIM) begin
            @(negedge clk);
            c++;
        end
        if (c >= LIM) checkOutput("release_timeout", 32'(bus.grant == '0), 32'd1);
    endtask

    task automatic waitPayload();
        int c;
        c = 0;
        while (bus.pl_ready == '0 && c < LIM) begin
            @(negedge clk);
            c++;
        end
        if (c >= LIM) checkOutput("payload_timeout", 32'(bus.pl_ready != '0), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0; errors = 0; under_cnt = 0; ready_seen = 1'b0;
        pl_limit = 1000; pl_en = '1; hdr_idx = 0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_src_port = '0; bus.req_dst_port = '0;
        bus.req_length = '0;   bus.req_cksum = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_grant", 32'(bus.grant), 32'd0);
        checkOutput("rst_hdr_start", 32'(bus.hdr_start), 32'd0);
        checkOutput("rst_pl_ready", 32'(bus.pl_ready), 32'd0);
        checkOutput("rst_axiov", 32'(bus.axiov), 32'd0);
        checkOutput("rst_axiod", 32'(bus.axiod), 32'd0);
        checkOutput("rst_axi_last", 32'(bus.axi_last), 32'd0);
        checkOutput("rst_underrun", 32'(bus.underrun), 32'd0);
        checkOutput("rst_src", 32'(bus.src_port_out), 32'd0);
        checkOutput("rst_len", 32'(bus.data_length_out), 32'd0);
        rst = 1'b0;

        $display("[TB] round robin");
        applyStimulus(0, 16'd53, 16'd554, 16'd4, 16'h9FCB);
        applyStimulus(1, 16'h1111, 16'h2222, 16'd2, 16'hABCD);
        for (int f = 0; f < 4; f++) begin
            if (f % 2 == 0) pushFrame(0, 16'd53, 16'd554, 16'd4, 16'h9FCB, 8, 1'b1);
            else            pushFrame(1, 16'h1111, 16'h2222, 16'd2, 16'hABCD, 4, 1'b1);
        end
        for (int f = 0; f < 4; f++) begin
            waitGrantHigh(n);
            checkOutput("rr_grant", 32'(bus.grant), (f % 2 == 0) ? 32'd1 : 32'd2);
            if (f > 0) checkOutput("rr_gap_len", 32'(n), 32'(GAP + 1));
            if (f == 3) bus.req_valid = '0;
            waitGrantLow();
        end
        repeat (3) @(negedge clk);
        checkOutput("rr_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] single frame and field stability");
        repeat (30) @(negedge clk);
        applyStimulus(0, 16'd53, 16'd554, 16'd4, 16'h9FCB);
        pushFrame(0, 16'd53, 16'd554, 16'd4, 16'h9FCB, 8, 1'b1);
        waitGrantHigh(n);
        checkOutput("sf_grant", 32'(bus.grant), 32'd1);
        checkOutput("sf_src", 32'(bus.src_port_out), 32'd53);
        checkOutput("sf_dst", 32'(bus.dst_port_out), 32'd554);
        checkOutput("sf_len", 32'(bus.data_length_out), 32'd4);
        checkOutput("sf_cksum", 32'(bus.data_checksum_out), 32'h9FCB);
        checkOutput("sf_hdr_start", 32'(bus.hdr_start), 32'd1);
        bus.req_length[15:0]   = 16'd100;
        bus.req_src_port[15:0] = 16'd7;
        waitPayload();
        checkOutput("fs_pl_ready", 32'(bus.pl_ready), 32'd1);
        checkOutput("fs_len_payload", 32'(bus.data_length_out), 32'd4);
        waitGrantLow();
        checkOutput("fs_len_gap", 32'(bus.data_length_out), 32'd4);
        applyStimulus(0, 16'd53, 16'd554, 16'd4, 16'h9FCB);
        pushFrame(0, 16'd53, 16'd554, 16'd4, 16'h9FCB, 8, 1'b1);
        waitGrantHigh(n);
        checkOutput("b2b_gap_len", 32'(n), 32'(GAP + 1));
        checkOutput("b2b_grant", 32'(bus.grant), 32'd1);
        bus.req_valid = '0;
        waitGrantLow();
        repeat (3) @(negedge clk);
        checkOutput("sf_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] zero length");
        repeat (30) @(negedge clk);
        ready_seen = 1'b0;
        applyStimulus(1, 16'h0400, 16'h0050, 16'd0, 16'h1234);
        pushFrame(1, 16'h0400, 16'h0050, 16'd0, 16'h1234, 0, 1'b1);
        waitGrantHigh(n);
        checkOutput("zl_grant", 32'(bus.grant), 32'd2);
        bus.req_valid = '0;
        waitGrantLow();
        repeat (3) @(negedge clk);
        checkOutput("zl_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("zl_pl_ready_seen", 32'(ready_seen), 32'd0);

        $display("[TB] underrun");
        repeat (30) @(negedge clk);
        under_cnt = 0;
        pl_limit  = 3;
        applyStimulus(0, 16'd53, 16'd554, 16'd4, 16'h9FCB);
        pushFrame(0, 16'd53, 16'd554, 16'd4, 16'h9FCB, 3, 1'b0);
        waitGrantHigh(n);
        checkOutput("ur_grant", 32'(bus.grant), 32'd1);
        bus.req_valid = '0;
        waitGrantLow();
        pl_limit = 1000;
        applyStimulus(1, 16'h1111, 16'h2222, 16'd2, 16'hABCD);
        pushFrame(1, 16'h1111, 16'h2222, 16'd2, 16'hABCD, 4, 1'b1);
        waitGrantHigh(n);
        checkOutput("ur_gap_len", 32'(n), 32'(GAP + 1));
        checkOutput("ur_next_grant", 32'(bus.grant), 32'd2);
        bus.req_valid = '0;
        waitGrantLow();
        repeat (3) @(negedge clk);
        checkOutput("ur_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("ur_pulses", 32'(under_cnt), 32'd1);

        $display("[TB] reset mid payload");
        repeat (30) @(negedge clk);
        applyStimulus(0, 16'd53, 16'd554, 16'd4, 16'h9FCB);
        pushFrame(0, 16'd53, 16'd554, 16'd4, 16'h9FCB, 8, 1'b1);
        waitGrantHigh(n);
        bus.req_valid = '0;
        waitPayload();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("mr_grant", 32'(bus.grant), 32'd0);
        checkOutput("mr_pl_ready", 32'(bus.pl_ready), 32'd0);
        checkOutput("mr_axiov", 32'(bus.axiov), 32'd0);
        checkOutput("mr_axiod", 32'(bus.axiod), 32'd0);
        checkOutput("mr_hdr_start", 32'(bus.hdr_start), 32'd0);
        checkOutput("mr_len", 32'(bus.data_length_out), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        applyStimulus(0, 16'd53, 16'd554, 16'd4, 16'h9FCB);
        applyStimulus(1, 16'h1111, 16'h2222, 16'd2, 16'hABCD);
        pushFrame(0, 16'd53, 16'd554, 16'd4, 16'h9FCB, 8, 1'b1);
        pushFrame(1, 16'h1111, 16'h2222, 16'd2, 16'hABCD, 4, 1'b1);
        rst = 1'b0;
        waitGrantHigh(n);
        checkOutput("mr_first_grant", 32'(bus.grant), 32'd1);
        waitGrantLow();
        waitGrantHigh(n);
        checkOutput("mr_second_grant", 32'(bus.grant), 32'd2);
        bus.req_valid = '0;
        waitGrantLow();
        repeat (3) @(negedge clk);
        checkOutput("mr_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_tx_sched.md
# udp_tx_sched

Frame scheduler for the UDP transmit path. Arbitrates round-robin between `NREQ` payload sources. For each frame it:
- latches the winner's port, length and checksum fields and drives them into the `udp_tx` header serializer;
- forwards the 8-byte header nibble stream;
- splices in the winner's payload nibbles;
- enforces an inter-frame gap.

It sits between the application-side packet sources and the IPv4/Ethernet framing stage.

## Interface
Parameters:
- `NREQ`, 2, number of requesters (2..8)
- `N`, 4, stream width in bits; legal values 2, 4, 8
- `GAP_CYCLES`, 24, idle cycles between frames (96 bit times at N=4)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NREQ  requester i has a complete packet ready
- `req_src_port`, `req_dst_port`, `req_length`, `req_cksum`  in  NREQ*16 each  per-requester header fields; slice i belongs to requester i; length is in payload bytes
- `grant`  out  NREQ  one-hot owner of the current frame, 0 when idle
- `src_port_out`, `dst_port_out`, `data_length_out`, `data_checksum_out`  out  16 each  latched fields to `udp_tx`
- `hdr_start`  out  1  drives `udp_tx` axiiv
- `hdr_valid`, `hdr_last`  in  1 each  `udp_tx` axiov / axi_last
- `hdr_data`  in  N  `udp_tx` axiod
- `pl_valid`  in  NREQ  payload nibble available from requester i
- `pl_data`  in  NREQ*N  payload nibbles
- `pl_ready`  out  NREQ  consume strobe; only the granted bit can be high
- `axiov`  out  1  merged stream valid
- `axiod`  out  N  merged stream data
- `axi_last`  out  1  last nibble of the UDP segment
- `underrun`  out  1  one-cycle pulse when a frame is aborted

## Operation
States: IDLE, HEADER, PAYLOAD, GAP.

- **IDLE**
  - If any `req_valid` is set, pick the first set bit searching upward from `rr_ptr`, wrapping.
  - Latch that requester's four fields, set `grant`, set `rr_ptr` = winner+1 mod NREQ, go to HEADER.
- **HEADER**
  - `hdr_start`=1.
  - Each `hdr_valid` cycle forwards `hdr_data` to `axiod`.
  - On `hdr_valid & hdr_last`:
    - length 0: that nibble carries `axi_last`=1 and the next state is GAP.
    - otherwise: load `nib_cnt` = length*8/N and go to PAYLOAD.
  - `hdr_start` drops the cycle after `hdr_last`.
- **PAYLOAD**
  - `pl_ready[g]`=1.
  - Each cycle with `pl_valid[g]` emits one nibble and decrements `nib_cnt`.
  - The nibble that takes `nib_cnt` from 1 to 0 carries `axi_last`, then go to GAP.
  - `pl_valid[g]`=0 in any PAYLOAD cycle:
    - the frame is aborted;
    - `underrun` pulses;
    - no `axi_last` is emitted;
    - the state goes to GAP.
- **GAP**
  - `grant`=0.
  - Count `GAP_CYCLES` cycles, then go to IDLE.
  - `req_valid` is ignored in this state.

Width rules and input changes:
- `nib_cnt` is 19 bits wide (65535*8/2). No overflow is possible.
- Changes to `req_*` fields after latching have no effect until the next frame.
- Deasserting `req_valid[g]` mid-frame has no effect on the current frame.
- Back-to-back requests from a single requester are served every frame.
- With all requesters active, service order is 0,1,…,NREQ-1,0.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `nib_cnt`=0. All outputs 0, including `grant`, fields, `hdr_start`, `pl_ready`, `axiov`, `axiod`, `axi_last`, `underrun`.
- `req_valid` sampled in IDLE at edge t:
  - `grant` and fields valid at t+1;
  - `hdr_start` high from t+1.
- `axiov`/`axiod`/`axi_last` are registered: exactly one cycle after the corresponding `hdr_*` or `pl_*` input cycle.
- `pl_ready` is combinational from state; a nibble is consumed on every cycle with `pl_ready & pl_valid`.
- Reset asserted mid-frame: all outputs clear asynchronously. After release, the block is in IDLE with `rr_ptr`=0 and the frame is lost.
- Header to payload: no bubble. The first payload nibble appears on `axiod` the cycle after the last header nibble.

## Structure
- Shared package `udp_pkg` holds:
  - the state enum;
  - `UDP_HDR_BYTES`=8;
  - the default inter-frame gap constant.
- Sub-module `rr_arbiter`, parameterized by NREQ:
  - inputs: request vector and pointer;
  - outputs: one-hot grant and winner index;
  - combinational.
- FSM, counters and stream mux live in `udp_tx_sched`.

## Test plan
- **Single frame.** Requester 0: src 53, dst 554, len 4, cksum 0x9FCB; real `udp_tx` (N=4) instantiated.
  - Expect 16 header nibbles 0,0,3,5,0,2,2,A,0,0,0,C,9,F,C,B, then 8 payload nibbles.
  - `axi_last` only on nibble 24.
  - Then 24 idle cycles.
- **Round-robin.** Both requesters valid continuously.
  - Grants alternate 0,1,0,1 over four frames.
  - `grant` is 0 during every GAP.
- **Zero length.** len 0: `axi_last` on the 16th header nibble; `pl_ready` never high.
- **Underrun.** len 4, drop `pl_valid` after 3 payload nibbles.
  - `underrun` pulses once; no `axi_last`; state reaches GAP, then IDLE.
- **Reset mid-PAYLOAD.** Assert `rst` during a frame.
  - All outputs 0 immediately.
  - After release, a new request from requester 1 is granted with `rr_ptr` restarting from 0.
- **Field stability.** Change `req_length` to 100 after grant.
  - Emitted frame still uses len 4; `data_length_out` stays 4 until GAP.
